// File: rtl/mtl_timing_generator.sv
// Raster timing generator for the 800x480 MTL panel: free-running h/v counters,
// zero-latency pixel request/coordinate decode, and a one-stage registered RGB/sync/DE output.
module mtl_timing_generator #(
   parameter int H_ACT   = 800,
   parameter int H_SYNC  = 1,
   parameter int H_BLANK = 46,
   parameter int H_TOTAL = 1056,
   parameter int V_ACT   = 480,
   parameter int V_SYNC  = 1,
   parameter int V_BLANK = 23,
   parameter int V_TOTAL = 525
) (
   input  logic        iCLK_33,
   input  logic        iRST,
   input  logic [31:0] i_pixel_data,
   output logic        o_new_frame,
   output logic        o_end_frame,
   output logic        o_next_active,
   output logic [10:0] o_current_x,
   output logic [9:0]  o_current_y,
   output logic [7:0]  o_lcd_r,
   output logic [7:0]  o_lcd_g,
   output logic [7:0]  o_lcd_b,
   output logic        o_lcd_hsd,
   output logic        o_lcd_vsd,
   output logic        o_lcd_de
);

   // Every boundary must be representable at counter width, and end-of-frame must land inside the frame.
   if (H_TOTAL > 2047 || V_TOTAL > 1023 || H_TOTAL < 1 || V_TOTAL < 1 ||
       H_BLANK + H_ACT > H_TOTAL || V_BLANK + V_ACT >= V_TOTAL ||
       H_SYNC > H_TOTAL || V_SYNC > V_TOTAL) begin : g_param_check
      $error("mtl_timing_generator: timing parameters do not fit the counters");
   end

   localparam logic [10:0] H_BLANK_C = 11'(H_BLANK);
   localparam logic [10:0] H_END_C   = 11'(H_BLANK + H_ACT);
   localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
   localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_BLANK_C = 10'(V_BLANK);
   localparam logic [9:0]  V_END_C   = 10'(V_BLANK + V_ACT);
   localparam logic [9:0]  V_SYNC_C  = 10'(V_SYNC);
   localparam logic [9:0]  V_LAST_C  = 10'(V_TOTAL - 1);

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [23:0] rgb_q, rgb_d;
   logic        de_q, de_d;
   logic        hsd_q, hsd_d;
   logic        vsd_q, vsd_d;
   logic        act;

   // Only the low 24 bits carry colour; the top byte is padding.
   logic        unused_pixel_bits;
   assign unused_pixel_bits = ^i_pixel_data[31:24];

   always_comb begin
      h_cnt_d = h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST_C) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 10'd1;
      end

      act = (h_cnt_q >= H_BLANK_C) && (h_cnt_q < H_END_C) &&
            (v_cnt_q >= V_BLANK_C) && (v_cnt_q < V_END_C);

      de_d  = act;
      rgb_d = act ? i_pixel_data[23:0] : '0;
      hsd_d = !(h_cnt_q < H_SYNC_C);
      vsd_d = !(v_cnt_q < V_SYNC_C);
   end

   always_ff @(posedge iCLK_33) begin
      if (iRST) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         rgb_q   <= '0;
         de_q    <= 1'b0;
         hsd_q   <= 1'b1;
         vsd_q   <= 1'b1;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         rgb_q   <= rgb_d;
         de_q    <= de_d;
         hsd_q   <= hsd_d;
         vsd_q   <= vsd_d;
      end
   end

   // Request-side decode is combinational so the controller's show-ahead word lines up with the register stage.
   always_comb begin
      o_next_active = 1'b0;
      o_current_x   = '0;
      o_current_y   = '0;
      o_new_frame   = 1'b0;
      o_end_frame   = 1'b0;
      if (!iRST) begin
         o_next_active = act;
         o_current_x   = act ? h_cnt_q - H_BLANK_C : '0;
         o_current_y   = act ? v_cnt_q - V_BLANK_C : '0;
         o_new_frame   = (h_cnt_q == '0) && (v_cnt_q == '0);
         o_end_frame   = (h_cnt_q == '0) && (v_cnt_q == V_END_C);
      end
   end

   assign o_lcd_r   = rgb_q[23:16];
   assign o_lcd_g   = rgb_q[15:8];
   assign o_lcd_b   = rgb_q[7:0];
   assign o_lcd_de  = de_q;
   assign o_lcd_hsd = hsd_q;
   assign o_lcd_vsd = vsd_q;

endmodule

// File: tb/tb_mtl_timing_generator.sv
// Directed bench: a small-parameter instance for frame-level behaviour and mid-frame reset,
// and a default-parameter instance run up to the start of the second active line.
module tb_mtl_timing_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small-parameter instance (H 4/1/2/8, V 3/1/1/6)
   logic        rst_s;
   logic [31:0] pix_s;
   logic        s_nf, s_ef, s_na, s_hsd, s_vsd, s_de;
   logic [10:0] s_x;
   logic [9:0]  s_y;
   logic [7:0]  s_r, s_g, s_b;

   // Default-parameter instance
   logic        rst_d;
   logic [31:0] pix_d;
   logic        d_nf, d_ef, d_na, d_hsd, d_vsd, d_de;
   logic [10:0] d_x;
   logic [9:0]  d_y;
   logic [7:0]  d_r, d_g, d_b;

   mtl_timing_generator #(
      .H_ACT(4), .H_SYNC(1), .H_BLANK(2), .H_TOTAL(8),
      .V_ACT(3), .V_SYNC(1), .V_BLANK(1), .V_TOTAL(6)
   ) u_dut_small (
      .iCLK_33(clk), .iRST(rst_s), .i_pixel_data(pix_s),
      .o_new_frame(s_nf), .o_end_frame(s_ef), .o_next_active(s_na),
      .o_current_x(s_x), .o_current_y(s_y),
      .o_lcd_r(s_r), .o_lcd_g(s_g), .o_lcd_b(s_b),
      .o_lcd_hsd(s_hsd), .o_lcd_vsd(s_vsd), .o_lcd_de(s_de)
   );

   mtl_timing_generator u_dut_full (
      .iCLK_33(clk), .iRST(rst_d), .i_pixel_data(pix_d),
      .o_new_frame(d_nf), .o_end_frame(d_ef), .o_next_active(d_na),
      .o_current_x(d_x), .o_current_y(d_y),
      .o_lcd_r(d_r), .o_lcd_g(d_g), .o_lcd_b(d_b),
      .o_lcd_hsd(d_hsd), .o_lcd_vsd(d_vsd), .o_lcd_de(d_de)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else begin
         n_pass++;
         $display("check %s ok (%0h)", tag, got);
      end
   endtask

   function automatic logic [31:0] pat(input int k);
      logic [31:0] kk;
      kk = k;
      return {8'hAA, kk[7:0] ^ 8'h3C, kk[15:8], 8'h5A};
   endfunction

   initial begin
      int          h, v;
      logic        act_e, prev_act;
      logic [31:0] prev_pix;
      logic        exp_hsd, exp_vsd;
      logic [23:0] exp_rgb;
      int          dec_err, data_err, sync_err;
      int          na_f0, na_f1, nf_cnt, ef_cnt, hsd_low, ef_after;
      int          first_act, na_full;

      rst_s = 1'b1; rst_d = 1'b1; pix_s = '0; pix_d = '0;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check("rst_nf_forced", 32'(s_nf), 32'd0);
      check("rst_hsd", 32'(s_hsd), 32'd1);
      check("rst_vsd", 32'(s_vsd), 32'd1);
      check("rst_de_rgb", {7'd0, s_de, s_r, s_g, s_b}, 32'd0);

      // Small instance: two full frames plus part of the third
      prev_act = 1'b0; prev_pix = '0;
      dec_err = 0; data_err = 0; sync_err = 0;
      na_f0 = 0; na_f1 = 0; nf_cnt = 0; ef_cnt = 0; hsd_low = 0;
      for (int k = 0; k < 115; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         pix_s = pat(k);
         #1;
         h = k % 8;
         v = (k / 8) % 6;
         act_e = (h >= 2) && (h < 6) && (v >= 1) && (v < 4);
         if (s_na !== act_e) dec_err++;
         if (act_e && (32'(s_x) != 32'(h - 2) || 32'(s_y) != 32'(v - 1))) dec_err++;
         if (!act_e && (s_x != 0 || s_y != 0)) dec_err++;
         exp_rgb = prev_act ? prev_pix[23:0] : 24'd0;
         if (s_de !== prev_act || {s_r, s_g, s_b} !== exp_rgb) data_err++;
         exp_hsd = (k == 0) ? 1'b1 : (((k - 1) % 8) != 0);
         exp_vsd = (k == 0) ? 1'b1 : ((((k - 1) / 8) % 6) != 0);
         if (s_hsd !== exp_hsd || s_vsd !== exp_vsd) sync_err++;
         if (k < 48 && s_na) na_f0++;
         if (k >= 48 && k < 96 && s_na) na_f1++;
         if (k < 96) begin
            if (s_nf) nf_cnt++;
            if (s_ef) ef_cnt++;
            if (k >= 1 && !s_hsd) hsd_low++;
         end
         if (k == 0) begin
            check("s_first_nf", 32'(s_nf), 32'd1);
            check("s_first_syncs", {30'd0, s_hsd, s_vsd}, 32'd3);
            check("s_first_de", 32'(s_de), 32'd0);
         end
         if (k == 1) check("s_hsd_low", 32'(s_hsd), 32'd0);
         if (k == 2) check("s_hsd_back", 32'(s_hsd), 32'd1);
         if (k == 10) check("s_first_px", {s_na, s_x, s_y}, {1'b1, 11'd0, 10'd0});
         if (k == 11) check("s_first_rgb", {7'd0, s_de, s_r, s_g, s_b}, {8'd1, pat(10)[23:0]});
         if (k == 29) check("s_last_px", {s_na, s_x, s_y}, {1'b1, 11'd3, 10'd2});
         if (k == 30) check("s_after_last", 32'(s_na), 32'd0);
         if (k == 32) check("s_end_frame", 32'(s_ef), 32'd1);
         if (k == 48) check("s_new_frame2", 32'(s_nf), 32'd1);
         prev_act = act_e;
         prev_pix = pix_s;
      end
      check("s_decode_errs", 32'(dec_err), 32'd0);
      check("s_data_errs", 32'(data_err), 32'd0);
      check("s_sync_errs", 32'(sync_err), 32'd0);
      check("s_na_frame0", 32'(na_f0), 32'd12);
      check("s_na_frame1", 32'(na_f1), 32'd12);
      check("s_nf_count", 32'(nf_cnt), 32'd2);
      check("s_ef_count", 32'(ef_cnt), 32'd2);
      check("s_hsd_low_cnt", 32'(hsd_low), 32'd12);

      // Mid-frame reset while h=3, v=2 (inside the active window)
      @(negedge clk);
      rst_s = 1'b1;
      #1;
      check("s_rst_na_forced", {s_na, s_x, s_y}, 32'd0);
      check("s_de_before_rst", 32'(s_de), 32'd1);
      @(negedge clk);
      rst_s = 1'b0;
      #1;
      check("s_rst_nf", 32'(s_nf), 32'd1);
      check("s_rst_de_drop", {7'd0, s_de, s_r, s_g, s_b}, 32'd0);
      ef_after = 0;
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk); #1;
         if (j < 32 && s_ef) ef_after++;
         if (j == 32) check("s_rst_ef_new", 32'(s_ef), 32'd1);
      end
      check("s_no_aborted_ef", 32'(ef_after), 32'd0);

      // Default instance: released after a long reset, run to the start of line two
      prev_act = 1'b0; prev_pix = '0; data_err = 0;
      first_act = -1; na_full = 0;
      for (int k = 0; k <= 25400; k++) begin
         @(negedge clk);
         rst_d = 1'b0;
         pix_d = pat(k);
         #1;
         if (d_na) begin
            na_full++;
            if (first_act < 0) first_act = k;
         end
         exp_rgb = d_de ? prev_pix[23:0] : 24'd0;
         if ({d_r, d_g, d_b} !== exp_rgb) data_err++;
         if (k == 0) check("d_first", {28'd0, d_nf, d_hsd, d_vsd, d_de}, 32'hE);
         if (k == 1) check("d_hsd_low", 32'(d_hsd), 32'd0);
         if (k == 2) check("d_hsd_back", 32'(d_hsd), 32'd1);
         if (k == 24333) check("d_pre_active", 32'(d_na), 32'd0);
         if (k == 24334) check("d_first_px", {d_na, d_de, d_x, d_y}, {1'b1, 1'b0, 11'd0, 10'd0});
         if (k == 24335) check("d_first_rgb", {7'd0, d_de, d_r, d_g, d_b}, {8'd1, pat(24334)[23:0]});
         if (k == 24335) check("d_x1", 32'(d_x), 32'd1);
         if (k == 25133) check("d_line_end", {d_na, d_x, d_y}, {1'b1, 11'd799, 10'd0});
         if (k == 25134) check("d_line_off", {30'd0, d_na, d_de}, 32'd1);
         if (k == 25135) check("d_de_off", 32'(d_de), 32'd0);
         if (k == 25390) check("d_line2", {d_na, d_x, d_y}, {1'b1, 11'd0, 10'd1});
         prev_pix = pix_d;
      end
      check("d_first_act_cycle", 32'(first_act), 32'd24334);
      check("d_na_count", 32'(na_full), 32'd811);
      check("d_data_errs", 32'(data_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mtl_timing_generator.md
Name: mtl_timing_generator

Overview:
Raster timing generator for the 800x480 MTL touch panel.
- Runs on the 33 MHz pixel clock.
- Produces the frame/line control pulses, pixel coordinates and read strobe consumed by the display controller.
- Registers the pixel word returned by the display controller onto the panel RGB/sync pins.
- Sits directly downstream of the display controller and drives the panel pins.

Parameters:
H_ACT, 800, active pixels per line
H_SYNC, 1, HSD low width (cycles)
H_BLANK, 46, cycles from line start to first active pixel (sync + back porch)
H_TOTAL, 1056, cycles per line
V_ACT, 480, active lines per frame
V_SYNC, 1, VSD low width (lines)
V_BLANK, 23, lines from frame start to first active line
V_TOTAL, 525, lines per frame

Ports:
iCLK_33  in  1  pixel clock, all logic on rising edge
iRST  in  1  synchronous active-high reset
i_pixel_data  in  32  show-ahead pixel word {8'x, R[7:0], G[7:0], B[7:0]}, valid in the cycle o_next_active=1
o_new_frame  out  1  one-cycle pulse at frame start
o_end_frame  out  1  one-cycle pulse after last active line
o_next_active  out  1  pixel request / read-acknowledge strobe
o_current_x  out  11  column of requested pixel
o_current_y  out  10  row of requested pixel
o_lcd_r, o_lcd_g, o_lcd_b  out  8 each  panel colour
o_lcd_hsd  out  1  horizontal sync, active low
o_lcd_vsd  out  1  vertical sync, active low
o_lcd_de  out  1  data enable

Behaviour:
- State: h_cnt (11 b) and v_cnt (10 b) registers.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
- Reset (iRST=1 at a clock edge):
  - h_cnt=0, v_cnt=0.
  - Registered panel outputs: r/g/b=0, de=0, hsd=1, vsd=1.
  - Decoded outputs are forced 0 while iRST=1.
  - Reset mid-frame aborts the frame. The first cycle after release has h=0, v=0, so o_new_frame=1.
- Active window: act = (H_BLANK <= h_cnt < H_BLANK+H_ACT) and (V_BLANK <= v_cnt < V_BLANK+V_ACT).
- Decoded outputs are combinational from the counter registers, with 0 latency:
  - o_next_active = act.
  - o_current_x = h_cnt-H_BLANK when act, else 0.
  - o_current_y = v_cnt-V_BLANK when act, else 0.
  - o_new_frame = (h_cnt==0 and v_cnt==0).
  - o_end_frame = (h_cnt==0 and v_cnt==V_BLANK+V_ACT).
  - new_frame and end_frame never coincide and each occurs exactly once per frame.
- Pixel pipeline has 1-cycle latency. At each edge:
  - o_lcd_de <= act.
  - {r,g,b} <= act ? i_pixel_data[23:0] : 0.
  - o_lcd_hsd <= !(h_cnt < H_SYNC).
  - o_lcd_vsd <= !(v_cnt < V_SYNC).
  - Result: sync, DE and colour stay mutually aligned.
- Handshake: i_pixel_data is sampled only when o_next_active=1. o_next_active is high for exactly H_ACT*V_ACT cycles per frame, matching the image read range of 384000 words.
- Arithmetic: all compares are unsigned at counter width. Parameter sums must fit in the counter widths (H_TOTAL<=2047, V_TOTAL<=1023); this is checked by an elaboration-time assertion.

Test Plan:
- Reset release: hold iRST 5 cycles then drop -> first post-reset cycle new_frame=1, hsd/vsd outputs 1, de=0. After 1 cycle o_lcd_hsd=0 for 1 cycle, then 1.
- First pixel: default params -> o_next_active first rises at cycle 23*1056+46=24334 after reset release, with x=0, y=0. o_lcd_de rises 1 cycle later, carrying i_pixel_data[23:0].
- Line/frame counts: run 2 frames -> exactly 384000 next_active cycles per frame; last one has x=799, y=479. o_end_frame at cycle 503*1056=531168; o_new_frame again at 554400.
- Data path: drive i_pixel_data = {8'hAA, y[7:0], x[7:0], 8'h5A} -> each de cycle shows g=x-1 low byte of the previous cycle, r, b=5A. Upper byte AA never appears; r/g/b are 0 whenever de=0.
- Mid-frame reset: assert iRST at v=200, h=500 for 1 cycle -> next cycle h=0, v=0, new_frame=1, de drops to 0 one cycle after reset, no end_frame for the aborted frame.
- Small params (H 4/1/2/8, V 3/1/1/6): verify wrap of h_cnt at 7 and v_cnt at 5, and hsd low 1 of 8 cycles. Period 48 cycles, 12 active.
